fht_input_loader: RTL and testbench
===================================

Name: fht_input_loader

Overview:
- Writer side of the FHT 4-bank working memory: accepts a stream of time-domain samples and writes them into the four RAM banks in bit-reversed order.
- When a full frame is stored, it pulses start to fht_control.
- It then holds off new samples until fht_control reports the conversion complete via its ready output.
- It sits between the sample source and the bank write ports. fht_control's read addressing assumes the layout this block produces.

Parameters:
A_BIT, 8, per-bank address width; one frame is N = 4*2^A_BIT points.
D_BIT, 16, sample width in bits.

Ports:
iCLK  in  1  clock.
iRESET  in  1  asynchronous, active-low reset.
iDATA  in  D_BIT  input sample.
iVALID  in  1  sample valid.
iSOF  in  1  start-of-frame marker, qualified by iVALID.
oREADY  out  1  loader can accept a sample this cycle.
oADDR_WR_0..oADDR_WR_3  out  A_BIT each  per-bank write address.
oDATA_0..oDATA_3  out  D_BIT each  per-bank write data.
oWE_0..oWE_3  out  1 each  per-bank write enable.
oSTART  out  1  one-cycle start pulse to fht_control iSTART.
iFHT_RDY  in  1  fht_control oRDY (low while converting).
oDONE  out  1  one-cycle pulse when the conversion of a loaded frame completes.
oFRAME_ERR  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (iRESET=0, asynchronous):
  - state=LOAD, cnt=0.
  - All registered outputs (addresses, data, WE, oSTART, oDONE, oFRAME_ERR) are 0.
  - oREADY is combinational and equals (state==LOAD), so it is 1 immediately after reset.
- States:
  - LOAD: accept = iVALID & oREADY.
    - On accept, cnt increments (N_BIT = A_BIT+2 bits).
    - When the accepted sample has cnt==N-1, go to FLUSH.
  - FLUSH: one cycle; the last write's WE is high. Go to START.
  - START: oSTART=1 for exactly one cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until iFHT_RDY==0, then go to WAIT_DONE.
  - WAIT_DONE: stay until iFHT_RDY==1, then oDONE=1 for one cycle, cnt=0, go to LOAD.
- Address mapping for the accepted sample index k:
  - r = bit-reverse of k over N_BIT bits.
  - bank = r[1:0].
  - address = r[N_BIT-1:2].
- Write timing:
  - Latency is 1 cycle: the cycle after an accept, exactly one oWE_b (b = bank) is 1.
  - In that cycle, oADDR_WR_b = address and oDATA_b = sample.
  - Non-selected banks have WE=0; their address and data hold their previous values.
  - At most one WE is high in any cycle.
- iSOF:
  - An accepted sample with iSOF=1 is treated as index 0, so cnt restarts at 1 after it.
  - If cnt!=0 at that moment, oFRAME_ERR pulses in the same cycle as the write of that sample. The earlier partial writes are simply overwritten later.
  - iSOF with cnt==0 is normal.
  - iSOF outside LOAD is ignored, because no sample is accepted.
- iFHT_RDY:
  - iFHT_RDY is ignored in LOAD and FLUSH.
  - If iFHT_RDY never drops after START, the block stays in WAIT_BUSY. There is no timeout.
- Wrap-around: cnt never exceeds N-1 in LOAD; it is reset to 0 on leaving WAIT_DONE.
- Simultaneous iSOF with the last sample (cnt==N-1):
  - iSOF wins: the sample is index 0, oFRAME_ERR=1, and the block stays in LOAD.
- Reset mid-frame or mid-conversion: return to LOAD with cnt=0 and outputs cleared. No start pulse is emitted.

Decomposition:
- fht_pkg holds:
  - the state enum (LOAD, FLUSH, START, WAIT_BUSY, WAIT_DONE);
  - the N_BIT and N localparams derived from A_BIT;
  - the bank-index width constant (2).
- Sub-module fht_bit_rev: a purely combinational N_BIT-wide bit reverser, parameterised by width. It is reused later by the output unloader.

Test Plan:
- A_BIT=2 (N=16), feed k=0..15 with iVALID=1 and data=100+k.
  - Required writes:
    - k=1: bank0 addr2 data101
    - k=3: bank0 addr3 data103
    - k=4: bank2 addr0 data104
    - k=15: bank3 addr3 data115
  - oSTART is high exactly 2 cycles after the 16th accept.
- After START, hold iFHT_RDY=1 for 5 cycles, then 0 for 20 cycles, then 1.
  - The block stays out of LOAD (oREADY=0) throughout.
  - oDONE pulses 1 cycle after iFHT_RDY rises; oREADY=1 the cycle after that.
- Feed 5 samples, then a sample with iSOF=1 and data=0xAA.
  - oFRAME_ERR=1 with the write to bank0 addr0 data 0xAA.
  - 15 further samples (16 total in the new frame) produce oSTART.
- Toggle iVALID 1/0 every cycle across a frame.
  - Exactly 16 WE pulses, never two WEs high in the same cycle.
  - oSTART is high exactly 2 cycles after the final accept.
- Assert iRESET=0 for 1 cycle during WAIT_BUSY.
  - All outputs are 0 asynchronously and oREADY=1.
  - The next frame's k=0 writes bank0 addr0, and only one oSTART pulse is seen per frame.
- A_BIT=8 (N=1024), full frame.
  - Each bank address 0..255 is written exactly once per bank (1024 writes total).
  - k=1 → bank0 addr128.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared types and sizing helpers for the FHT working-memory datapath.
// Shared by the input loader and the output unloader.
package fht_pkg;

    typedef enum logic [2:0] {
        LOAD,
        FLUSH,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } fht_state_t;

    localparam int unsigned BANK_BIT = 2;

    function automatic int unsigned n_bit_of(input int unsigned a_bit);
        return a_bit + BANK_BIT;
    endfunction

    function automatic int unsigned n_of(input int unsigned a_bit);
        return 32'd1 << n_bit_of(a_bit);
    endfunction

    // Sizes for the default 8-bit bank address build.
    localparam int unsigned DEF_A_BIT = 8;
    localparam int unsigned DEF_N_BIT = DEF_A_BIT + BANK_BIT;
    localparam int unsigned DEF_N     = 32'd1 << DEF_N_BIT;

endpackage

// File: rtl/fht_bit_rev.sv
// Combinational bit reverser, used for FHT sample index to bank/address mapping.
module fht_bit_rev #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < W; i++) begin
            dout[i] = din[W-1-i];
        end
    end

endmodule

// File: rtl/fht_input_loader.sv
// Writes a frame of samples into the four FHT banks in bit-reversed order,
// then starts the conversion and waits for it to finish before loading again.
module fht_input_loader
    import fht_pkg::*;
#(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    input  logic             iSOF,
    output logic             oREADY,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic [D_BIT-1:0] oDATA_0,
    output logic [D_BIT-1:0] oDATA_1,
    output logic [D_BIT-1:0] oDATA_2,
    output logic [D_BIT-1:0] oDATA_3,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    input  logic             iFHT_RDY,
    output logic             oDONE,
    output logic             oFRAME_ERR
);

    localparam int unsigned N_BIT = n_bit_of(A_BIT);
    localparam logic [N_BIT-1:0] LAST_IDX = '1;

    fht_state_t state, state_nxt;
    logic [N_BIT-1:0]    cnt, idx, rev;
    logic [BANK_BIT-1:0] bank;
    logic [A_BIT-1:0]    addr;
    logic                accept, start_nxt, done_nxt;

    logic [A_BIT-1:0] addr_q [4];
    logic [D_BIT-1:0] data_q [4];
    logic [3:0]       we_q;
    logic             start_q, done_q, ferr_q;

    assign oREADY = (state == LOAD);
    assign accept = iVALID & oREADY;
    // A start-of-frame sample always lands at index 0, regardless of the count.
    assign idx    = iSOF ? '0 : cnt;

    fht_bit_rev #(.W(N_BIT)) u_bit_rev (
        .din  (idx),
        .dout (rev)
    );

    assign bank = rev[BANK_BIT-1:0];
    assign addr = rev[N_BIT-1:BANK_BIT];

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            LOAD:      if (accept && idx == LAST_IDX) state_nxt = FLUSH;
            FLUSH: begin
                state_nxt = START;
                start_nxt = 1'b1;
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!iFHT_RDY) state_nxt = WAIT_DONE;
            WAIT_DONE: if (iFHT_RDY) begin
                state_nxt = LOAD;
                done_nxt  = 1'b1;
            end
            default:   state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= idx + 1'b1;
            else if (done_nxt)
                cnt <= '0;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int unsigned b = 0; b < 4; b++) begin
                addr_q[b] <= '0;
                data_q[b] <= '0;
            end
            we_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            we_q    <= '0;
            start_q <= start_nxt;
            done_q  <= done_nxt;
            ferr_q  <= accept & iSOF & (cnt != '0);
            if (accept) begin
                we_q[bank]   <= 1'b1;
                addr_q[bank] <= addr;
                data_q[bank] <= iDATA;
            end
        end
    end

    assign oADDR_WR_0 = addr_q[0];
    assign oADDR_WR_1 = addr_q[1];
    assign oADDR_WR_2 = addr_q[2];
    assign oADDR_WR_3 = addr_q[3];
    assign oDATA_0    = data_q[0];
    assign oDATA_1    = data_q[1];
    assign oDATA_2    = data_q[2];
    assign oDATA_3    = data_q[3];
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oSTART     = start_q;
    assign oDONE      = done_q;
    assign oFRAME_ERR = ferr_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: a 16-point instance for protocol corners
// and a 1024-point instance for full address coverage.
module tb_fht_input_loader;

    typedef struct {
        int unsigned bank;
        int unsigned addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // small instance, A_BIT=2
    logic        s_valid, s_sof, s_rdy, s_ready, s_start, s_done, s_ferr;
    logic [15:0] s_data;
    logic [1:0]  s_addr [4];
    logic [15:0] s_dout [4];
    logic        s_we   [4];

    // large instance, A_BIT=8
    logic        b_valid, b_sof, b_rdy, b_ready, b_start, b_done, b_ferr;
    logic [15:0] b_data;
    logic [7:0]  b_addr [4];
    logic [15:0] b_dout [4];
    logic        b_we   [4];

    int checks = 0;
    int errors = 0;
    int s_we_pulses = 0;
    int s_start_pulses = 0;
    int b_hits [4][256];
    vec_t tbl [16];

    fht_input_loader #(.A_BIT(2), .D_BIT(16)) u_small (
        .iCLK(clk), .iRESET(rst_n), .iDATA(s_data), .iVALID(s_valid), .iSOF(s_sof),
        .oREADY(s_ready),
        .oADDR_WR_0(s_addr[0]), .oADDR_WR_1(s_addr[1]), .oADDR_WR_2(s_addr[2]), .oADDR_WR_3(s_addr[3]),
        .oDATA_0(s_dout[0]), .oDATA_1(s_dout[1]), .oDATA_2(s_dout[2]), .oDATA_3(s_dout[3]),
        .oWE_0(s_we[0]), .oWE_1(s_we[1]), .oWE_2(s_we[2]), .oWE_3(s_we[3]),
        .oSTART(s_start), .iFHT_RDY(s_rdy), .oDONE(s_done), .oFRAME_ERR(s_ferr)
    );

    fht_input_loader #(.A_BIT(8), .D_BIT(16)) u_big (
        .iCLK(clk), .iRESET(rst_n), .iDATA(b_data), .iVALID(b_valid), .iSOF(b_sof),
        .oREADY(b_ready),
        .oADDR_WR_0(b_addr[0]), .oADDR_WR_1(b_addr[1]), .oADDR_WR_2(b_addr[2]), .oADDR_WR_3(b_addr[3]),
        .oDATA_0(b_dout[0]), .oDATA_1(b_dout[1]), .oDATA_2(b_dout[2]), .oDATA_3(b_dout[3]),
        .oWE_0(b_we[0]), .oWE_1(b_we[1]), .oWE_2(b_we[2]), .oWE_3(b_we[3]),
        .oSTART(b_start), .iFHT_RDY(b_rdy), .oDONE(b_done), .oFRAME_ERR(b_ferr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic s_step(input logic v, input logic sof, input logic [15:0] d);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string name, input int unsigned bank,
                               input int unsigned addr, input int unsigned data);
        for (int b = 0; b < 4; b++)
            chk({name, "_we"}, 32'(s_we[b]), (b == int'(bank)) ? 32'd1 : 32'd0);
        chk({name, "_addr"}, 32'(s_addr[bank]), addr);
        chk({name, "_data"}, 32'(s_dout[bank]), data);
    endtask

    task automatic s_finish_conv();
        s_rdy = 1'b0;
        repeat (3) s_step(1'b0, 1'b0, 16'd0);
        chk("conv_busy_ready", 32'(s_ready), 0);
        s_rdy = 1'b1;
        s_step(1'b0, 1'b0, 16'd0);
        chk("conv_done", 32'(s_done), 1);
        s_step(1'b0, 1'b0, 16'd0);
        chk("conv_done_clear", 32'(s_done), 0);
        chk("conv_ready", 32'(s_ready), 1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            n = 0;
            for (int b = 0; b < 4; b++) if (s_we[b]) n++;
            if (n != 0) chk("small_one_we", n, 1);
            s_we_pulses += n;
            if (s_start) s_start_pulses++;
            n = 0;
            for (int b = 0; b < 4; b++) begin
                if (b_we[b]) begin
                    n++;
                    b_hits[b][b_addr[b]]++;
                end
            end
            if (n != 0) chk("big_one_we", n, 1);
        end
    end

    initial begin
        int exp_bank [16] = '{0, 0, 0, 0, 2, 2, 2, 2, 1, 1, 1, 1, 3, 3, 3, 3};
        int exp_addr [16] = '{0, 2, 1, 3, 0, 2, 1, 3, 0, 2, 1, 3, 0, 2, 1, 3};
        int bad;
        int total;
        for (int i = 0; i < 16; i++) begin
            tbl[i].bank = exp_bank[i];
            tbl[i].addr = exp_addr[i];
        end
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++) b_hits[b][a] = 0;

        rst_n = 1'b0;
        s_valid = 1'b0; s_sof = 1'b0; s_data = '0; s_rdy = 1'b1;
        b_valid = 1'b0; b_sof = 1'b0; b_data = '0; b_rdy = 1'b1;
        #12;
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_we0", 32'(s_we[0]), 0);
        chk("rst_start", 32'(s_start), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_ferr", 32'(s_ferr), 0);
        chk("rst_data3", 32'(s_dout[3]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full frame in order, data 100+k
        for (int k = 0; k < 16; k++) begin
            s_step(1'b1, 1'b0, 16'(100 + k));
            check_write("frame1", tbl[k].bank, tbl[k].addr, 100 + k);
        end
        chk("frame1_start_early", 32'(s_start), 0);
        s_step(1'b0, 1'b0, 16'd0);
        chk("frame1_start", 32'(s_start), 1);
        chk("frame1_ready_low", 32'(s_ready), 0);
        s_step(1'b0, 1'b0, 16'd0);
        chk("frame1_start_once", 32'(s_start), 0);

        // ready stays high for 5 cycles, then low for 20: still busy throughout
        for (int i = 0; i < 25; i++) begin
            s_rdy = (i < 5) ? 1'b1 : 1'b0;
            s_step(1'b0, 1'b0, 16'd0);
            chk("busy_ready", 32'(s_ready), 0);
            chk("busy_done", 32'(s_done), 0);
        end
        s_rdy = 1'b1;
        s_step(1'b0, 1'b0, 16'd0);
        chk("done_pulse", 32'(s_done), 1);
        s_step(1'b0, 1'b0, 16'd0);
        chk("done_clear", 32'(s_done), 0);
        chk("ready_after_done", 32'(s_ready), 1);

        // partial frame discarded by start-of-frame
        for (int k = 0; k < 5; k++) s_step(1'b1, 1'b0, 16'(50 + k));
        chk("pre_sof_ferr", 32'(s_ferr), 0);
        s_step(1'b1, 1'b1, 16'h00AA);
        chk("sof_ferr", 32'(s_ferr), 1);
        check_write("sof", 0, 0, 'hAA);
        for (int k = 1; k < 16; k++) begin
            s_step(1'b1, 1'b0, 16'(200 + k));
            check_write("sof_frame", tbl[k].bank, tbl[k].addr, 200 + k);
            if (k == 1) chk("sof_ferr_clear", 32'(s_ferr), 0);
        end
        s_step(1'b0, 1'b0, 16'd0);
        chk("sof_frame_start", 32'(s_start), 1);
        s_finish_conv();

        // start-of-frame together with the would-be last sample
        for (int k = 0; k < 15; k++) s_step(1'b1, 1'b0, 16'(k));
        s_step(1'b1, 1'b1, 16'h0077);
        chk("last_sof_ferr", 32'(s_ferr), 1);
        chk("last_sof_ready", 32'(s_ready), 1);
        check_write("last_sof", 0, 0, 'h77);
        for (int k = 1; k < 16; k++) s_step(1'b1, 1'b0, 16'(k));
        chk("last_sof_no_start", 32'(s_start), 0);
        s_step(1'b0, 1'b0, 16'd0);
        chk("last_sof_start", 32'(s_start), 1);
        s_finish_conv();

        // valid toggling every cycle, start-of-frame on an empty count
        s_we_pulses = 0;
        s_start_pulses = 0;
        for (int i = 0; i < 32; i++) begin
            s_step((i % 2) == 0, i == 0, 16'(i));
            if (i == 0) chk("toggle_sof_ok", 32'(s_ferr), 0);
            if (i == 30) chk("toggle_start_early", 32'(s_start), 0);
        end
        chk("toggle_start", 32'(s_start), 1);
        s_finish_conv();
        chk("toggle_we_pulses", s_we_pulses, 16);
        chk("toggle_start_pulses", s_start_pulses, 1);

        // asynchronous reset while waiting for the converter to go busy
        for (int k = 0; k < 16; k++) s_step(1'b1, 1'b0, 16'(100 + k));
        s_step(1'b0, 1'b0, 16'd0);
        s_step(1'b0, 1'b0, 16'd0);
        chk("pre_reset_busy", 32'(s_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(s_ready), 1);
        chk("arst_data3", 32'(s_dout[3]), 0);
        chk("arst_addr3", 32'(s_addr[3]), 0);
        chk("arst_start", 32'(s_start), 0);
        chk("arst_done", 32'(s_done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_start_pulses = 0;
        for (int k = 0; k < 16; k++) begin
            s_step(1'b1, 1'b0, 16'(300 + k));
            check_write("post_rst", tbl[k].bank, tbl[k].addr, 300 + k);
        end
        s_step(1'b0, 1'b0, 16'd0);
        s_finish_conv();
        chk("post_rst_start_pulses", s_start_pulses, 1);

        // 1024-point frame on the large instance
        for (int k = 0; k < 1024; k++) begin
            b_valid = 1'b1;
            b_data  = 16'(k);
            @(posedge clk);
            #1;
            if (k == 1) begin
                chk("big_k1_we0", 32'(b_we[0]), 1);
                chk("big_k1_addr", 32'(b_addr[0]), 128);
                chk("big_k1_data", 32'(b_dout[0]), 1);
            end
        end
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("big_start", 32'(b_start), 1);
        @(posedge clk);
        #1;
        bad = 0;
        total = 0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 256; a++) begin
                if (b_hits[b][a] != 1) bad++;
                total += b_hits[b][a];
            end
        chk("big_addr_once", bad, 0);
        chk("big_total", total, 1024);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
